// File: rtl/ex_alu_core_if.sv
// rtl/ex_alu_core_if.sv - request/response handshake bundle between pipeline control and ex_alu_core
interface ex_alu_core_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        alu_ctrl;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result;
  logic              zero;
  logic              overflow;
  logic              illegal;

  modport master (
    output in_valid, alu_ctrl, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero, overflow, illegal
  );

  modport slave (
    input  in_valid, alu_ctrl, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero, overflow, illegal
  );
endinterface

// File: rtl/ex_alu_core.sv
// rtl/ex_alu_core.sv - EX-stage ALU: 1-cycle add/sub/and/or/slt, bit-serial shifts, registered result+flags
// Optional macro ALU_MUL_EN compiles in an iterative shift-add multiplier on alu_ctrl 011.
module ex_alu_core #(
  parameter int DATA_W = 16
) (
  input logic          clock,
  input logic          reset,
  ex_alu_core_if.slave bus
);
  localparam int SH_W = $clog2(DATA_W);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;
`ifdef ALU_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b011;

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, MUL = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t            state;
  logic [DATA_W-1:0] result_q;
  logic              zero_q;
  logic              overflow_q;
  logic              illegal_q;
  logic              out_valid_q;

  logic [DATA_W-1:0] shift_acc;
  logic [SH_W-1:0]   shift_cnt;
  logic              shift_left;
  logic [DATA_W-1:0] shift_next;

  logic              accept;
  logic [SH_W-1:0]   shamt;
  logic              start_shift;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic              add_ovf;
  logic              sub_ovf;
  logic [DATA_W-1:0] imm_result;
  logic              imm_ovf;
  logic              imm_illegal;

`ifdef ALU_MUL_EN
  logic [2*DATA_W-1:0] mul_mcand;
  logic [2*DATA_W-1:0] mul_prod;
  logic [2*DATA_W-1:0] mul_prod_next;
  logic [DATA_W-1:0]   mul_mplier;
  logic [SH_W-1:0]     mul_cnt;
  logic                start_mul;

  assign start_mul     = (bus.alu_ctrl == OP_MUL);
  assign mul_prod_next = mul_prod + (mul_mplier[0] ? mul_mcand : '0);
`endif

  assign bus.in_ready  = ~reset & ((state == IDLE) | ((state == DONE) & bus.out_ready));
  assign accept        = bus.in_valid & bus.in_ready;

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = overflow_q;
  assign bus.illegal   = illegal_q;

  assign shamt       = bus.op_b[SH_W-1:0];
  assign start_shift = ((bus.alu_ctrl == OP_SLL) | (bus.alu_ctrl == OP_SRL)) & (shamt != '0);
  assign shift_next  = shift_left ? (shift_acc << 1) : (shift_acc >> 1);

  assign sum     = bus.op_a + bus.op_b;
  assign diff    = bus.op_a - bus.op_b;
  assign add_ovf = (bus.op_a[DATA_W-1] == bus.op_b[DATA_W-1]) & (sum[DATA_W-1]  != bus.op_a[DATA_W-1]);
  assign sub_ovf = (bus.op_a[DATA_W-1] != bus.op_b[DATA_W-1]) & (diff[DATA_W-1] != bus.op_a[DATA_W-1]);

  // Immediate result for every op that completes on the accept edge (shift by 0 passes op_a).
  always_comb begin
    imm_result  = '0;
    imm_ovf     = 1'b0;
    imm_illegal = 1'b0;
    case (bus.alu_ctrl)
      OP_ADD: begin
        imm_result = sum;
        imm_ovf    = add_ovf;
      end
      OP_SUB: begin
        imm_result = diff;
        imm_ovf    = sub_ovf;
      end
      OP_AND:         imm_result = bus.op_a & bus.op_b;
      OP_OR:          imm_result = bus.op_a | bus.op_b;
      OP_SLT:         imm_result = {{(DATA_W-1){1'b0}}, diff[DATA_W-1] ^ sub_ovf};
      OP_SLL, OP_SRL: imm_result = bus.op_a;
`ifdef ALU_MUL_EN
      OP_MUL:         imm_result = '0;
`endif
      default:        imm_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      result_q    <= '0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
      shift_acc   <= '0;
      shift_cnt   <= '0;
      shift_left  <= 1'b0;
`ifdef ALU_MUL_EN
      mul_mcand   <= '0;
      mul_prod    <= '0;
      mul_mplier  <= '0;
      mul_cnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            if (start_shift) begin
              state       <= SHIFT;
              out_valid_q <= 1'b0;
              shift_acc   <= bus.op_a;
              shift_cnt   <= shamt;
              shift_left  <= (bus.alu_ctrl == OP_SLL);
            end
`ifdef ALU_MUL_EN
            else if (start_mul) begin
              state       <= MUL;
              out_valid_q <= 1'b0;
              mul_mcand   <= {{DATA_W{1'b0}}, bus.op_a};
              mul_mplier  <= bus.op_b;
              mul_prod    <= '0;
              mul_cnt     <= '0;
            end
`endif
            else begin
              state       <= DONE;
              out_valid_q <= 1'b1;
              result_q    <= imm_result;
              zero_q      <= (imm_result == '0);
              overflow_q  <= imm_ovf;
              illegal_q   <= imm_illegal;
            end
          end else if ((state == DONE) && bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
          end
        end

        SHIFT: begin
          shift_acc <= shift_next;
          shift_cnt <= shift_cnt - SH_W'(1);
          if (shift_cnt == SH_W'(1)) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            result_q    <= shift_next;
            zero_q      <= (shift_next == '0);
            overflow_q  <= 1'b0;
            illegal_q   <= 1'b0;
          end
        end

`ifdef ALU_MUL_EN
        // One multiplier bit per cycle; the last iteration's sum goes straight to the result register.
        MUL: begin
          mul_prod   <= mul_prod_next;
          mul_mcand  <= mul_mcand << 1;
          mul_mplier <= mul_mplier >> 1;
          mul_cnt    <= mul_cnt + SH_W'(1);
          if (mul_cnt == SH_W'(DATA_W-1)) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            result_q    <= mul_prod_next[DATA_W-1:0];
            zero_q      <= (mul_prod_next[DATA_W-1:0] == '0);
            overflow_q  <= (mul_prod_next[2*DATA_W-1:DATA_W] != '0);
            illegal_q   <= 1'b0;
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end
endmodule
